// File: rtl/pc_epc_unit.sv
// Program counter with exception-PC capture and a fixed four-edge vector fetch.
// On an exception the handler address is read as one byte from a fixed memory vector.
module pc_epc_unit #(
   parameter logic [31:0] OPC_VEC = 32'd253,
   parameter logic [31:0] OVF_VEC = 32'd254,
   parameter logic [31:0] DIV_VEC = 32'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic [1:0]  branch_op,
   input  logic        alu_zero,
   input  logic        alu_gt,
   input  logic        exc_opcode,
   input  logic        exc_ovf,
   input  logic        exc_div0,
   input  logic [7:0]  mem_byte,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic [31:0] exc_addr,
   output logic        exc_mem_sel,
   output logic        exc_busy,
   output logic        exc_done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_LOAD} state_t;

   state_t      state_q;
   logic [31:0] pc_q, epc_q, exc_addr_q;
   logic        br_taken, exc_req;
   logic [31:0] vec_d;

   always_comb begin
      br_taken = 1'b0;
      unique case (branch_op)
         2'b00: br_taken = alu_zero;
         2'b01: br_taken = !alu_zero;
         2'b10: br_taken = !alu_gt;
         2'b11: br_taken = alu_gt;
         default: br_taken = 1'b0;
      endcase
   end

   assign exc_req = exc_opcode | exc_ovf | exc_div0;

   // Opcode fault outranks overflow, which outranks divide-by-zero.
   always_comb begin
      vec_d = DIV_VEC;
      if (exc_opcode)   vec_d = OPC_VEC;
      else if (exc_ovf) vec_d = OVF_VEC;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         epc_q      <= '0;
         exc_addr_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (exc_req) begin
                  // PC is already past the faulting instruction; back up one word.
                  epc_q      <= pc_q - 32'd4;
                  exc_addr_q <= vec_d;
                  state_q    <= S_FETCH;
               end else if (pc_write || (pc_write_cond && br_taken)) begin
                  pc_q <= pc_next;
               end
            end
            S_FETCH: state_q <= S_WAIT;
            S_WAIT:  state_q <= S_LOAD;
            S_LOAD: begin
               pc_q    <= {24'b0, mem_byte};
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pc          = pc_q;
   assign epc         = epc_q;
   assign exc_addr    = exc_addr_q;
   assign exc_busy    = (state_q != S_IDLE);
   assign exc_mem_sel = (state_q != S_IDLE);
   assign exc_done    = (state_q == S_LOAD);

endmodule

// File: tb/tb_pc_epc_unit.sv
// Directed bench for pc_epc_unit: a countdown-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pc_epc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_next;
   logic        pc_write, pc_write_cond;
   logic [1:0]  branch_op;
   logic        alu_zero, alu_gt;
   logic        exc_opcode, exc_ovf, exc_div0;
   logic [7:0]  mem_byte;
   logic [31:0] pc, epc, exc_addr;
   logic        exc_mem_sel, exc_busy, exc_done;

   int n_chk  = 0;
   int n_fail = 0;

   pc_epc_unit dut (
      .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
      .alu_gt(alu_gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
      .mem_byte(mem_byte), .pc(pc), .epc(epc), .exc_addr(exc_addr),
      .exc_mem_sel(exc_mem_sel), .exc_busy(exc_busy), .exc_done(exc_done)
   );

   always #5 clk = ~clk;

   // Reference model: m_left counts busy cycles still to come (3 = just entered).
   logic [31:0] m_pc = 0, m_epc = 0, m_addr = 0;
   int          m_left = 0;

   function automatic bit taken(input logic [1:0] op, input logic z, input logic g);
      case (op)
         2'd0: return z;
         2'd1: return !z;
         2'd2: return !g;
         default: return g;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 0; m_epc = 0; m_addr = 0; m_left = 0;
      end else if (m_left == 0) begin
         if (exc_opcode || exc_ovf || exc_div0) begin
            m_epc  = m_pc - 32'd4;
            m_addr = exc_opcode ? 32'd253 : exc_ovf ? 32'd254 : 32'd255;
            m_left = 3;
         end else if (pc_write || (pc_write_cond && taken(branch_op, alu_zero, alu_gt))) begin
            m_pc = pc_next;
         end
      end else begin
         if (m_left == 1) m_pc = {24'b0, mem_byte};
         m_left = m_left - 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model pc", pc, m_pc);
      chk("model epc", epc, m_epc);
      chk("model exc_addr", exc_addr, m_addr);
      chk("model exc_busy", {31'b0, exc_busy}, {31'b0, m_left != 0});
      chk("model exc_mem_sel", {31'b0, exc_mem_sel}, {31'b0, m_left != 0});
      chk("model exc_done", {31'b0, exc_done}, {31'b0, m_left == 1});
   end

   // Inputs are applied right after a falling edge; tick advances one rising edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      pc_write = 0; pc_write_cond = 0; branch_op = 0; alu_zero = 0; alu_gt = 0;
      exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
   endtask

   initial begin
      reset = 1; pc_next = 0; mem_byte = 0;
      idle_inputs();
      #1;
      chk("reset pc", pc, 32'h0);
      chk("reset busy", {31'b0, exc_busy}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 0;

      // Unconditional write and hold
      pc_write = 1; pc_next = 32'h100; tick();
      pc_next = 32'h104; tick();
      chk("pc_write", pc, 32'h104);
      pc_write = 0; pc_next = 32'h200; tick();
      chk("pc hold", pc, 32'h104);

      // Every branch op with every flag combination
      for (int op = 0; op < 4; op++) begin
         for (int f = 0; f < 4; f++) begin
            pc_write_cond = 1; branch_op = op[1:0];
            alu_zero = f[0]; alu_gt = f[1];
            pc_next = 32'h1000 + 32'(op * 16 + f * 4);
            tick();
         end
      end
      pc_write_cond = 1; branch_op = 2'b01; alu_zero = 1; alu_gt = 0;
      pc_next = 32'h500; tick();
      chk("bne zero holds", pc, 32'h103C);
      branch_op = 2'b11; alu_zero = 0; alu_gt = 1; pc_next = 32'h600; tick();
      chk("bgt gt taken", pc, 32'h600);
      idle_inputs();

      // Overflow exception races a pc_write
      pc_write = 1; pc_next = 32'h40; tick();
      exc_ovf = 1; pc_write = 1; pc_next = 32'h999; tick();
      chk("ovf epc", epc, 32'h3C);
      chk("ovf exc_addr", exc_addr, 32'd254);
      chk("ovf pc held", pc, 32'h40);
      idle_inputs(); pc_write = 1; mem_byte = 8'h80; tick();
      tick();
      chk("ovf exc_done", {31'b0, exc_done}, 32'h1);
      pc_write = 0; tick();
      chk("ovf pc loaded", pc, 32'h80);
      chk("ovf idle", {31'b0, exc_busy}, 32'h0);

      // Simultaneous requests, then a request while busy
      exc_opcode = 1; exc_ovf = 1; exc_div0 = 1; tick();
      chk("prio exc_addr", exc_addr, 32'd253);
      chk("prio epc", epc, 32'h7C);
      idle_inputs(); tick();
      exc_div0 = 1; tick();
      chk("busy epc unchanged", epc, 32'h7C);
      chk("busy addr unchanged", exc_addr, 32'd253);
      idle_inputs(); mem_byte = 8'h33; tick();
      chk("prio pc loaded", pc, 32'h33);

      // Reset in WAIT, then a wrap-around exception from pc 0
      exc_div0 = 1; tick();
      idle_inputs(); tick();
      #2 reset = 1;
      #1;
      chk("mid reset pc", pc, 32'h0);
      chk("mid reset epc", epc, 32'h0);
      chk("mid reset busy", {31'b0, exc_busy}, 32'h0);
      chk("mid reset sel", {31'b0, exc_mem_sel}, 32'h0);
      @(negedge clk);
      reset = 0;
      exc_div0 = 1; tick();
      chk("wrap epc", epc, 32'hFFFFFFFC);
      chk("wrap exc_addr", exc_addr, 32'd255);
      idle_inputs(); mem_byte = 8'hA5; tick();
      chk("wrap pc not yet 2", pc, 32'h0);
      tick();
      chk("wrap pc not yet 3", pc, 32'h0);
      tick();
      chk("wrap pc loaded", pc, 32'hA5);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_epc_unit.md
PC_EPC_UNIT -- requirements
Module: pc_epc_unit

Interface
Parameters (name, default, meaning):
REQ-001 OPC_VEC, 32'd253, memory byte address holding the handler address for an invalid opcode.
REQ-002 OVF_VEC, 32'd254, memory byte address holding the handler address for an overflow.
REQ-003 DIV_VEC, 32'd255, memory byte address holding the handler address for a divide-by-zero.
Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc_next  in  32  candidate PC from the PC-source mux output.
REQ-007 pc_write  in  1  unconditional PC write enable.
REQ-008 pc_write_cond  in  1  conditional (branch) PC write enable.
REQ-009 branch_op  in  2  00 beq, 01 bne, 10 ble, 11 bgt.
REQ-010 alu_zero  in  1  ALU zero flag.
REQ-011 alu_gt  in  1  ALU greater-than flag.
REQ-012 exc_opcode, exc_ovf, exc_div0  in  1 each  exception requests from control/ALU/divider.
REQ-013 mem_byte  in  8  low byte of memory read data.
REQ-014 pc  out  32  program counter register.
REQ-015 epc  out  32  exception PC register; feeds the PC-source mux epc input.
REQ-016 exc_addr  out  32  vector address for memory during the fetch phase.
REQ-017 exc_mem_sel  out  1  high: memory address mux selects exc_addr.
REQ-018 exc_busy  out  1  high whenever state is not IDLE.
REQ-019 exc_done  out  1  one-cycle pulse in LOAD.

Function
REQ-020 FSM states: IDLE, FETCH, WAIT, LOAD; encoding free; no other reachable state.
REQ-021 Branch condition: beq=alu_zero; bne=!alu_zero; ble=!alu_gt; bgt=alu_gt.
REQ-022 IDLE, no exception request: pc <= pc_next when pc_write OR (pc_write_cond AND cond); otherwise pc holds.
REQ-023 IDLE, any exception request high at an edge: epc <= pc - 32'd4 (mod 2^32); exc_addr <= vector; state -> FETCH; pc NOT written that edge even if pc_write is high.
REQ-024 Vector priority when several requests are simultaneous: exc_opcode > exc_ovf > exc_div0.
REQ-025 FETCH: exc_mem_sel=1; next state WAIT (covers one-cycle registered memory latency).
REQ-026 WAIT: exc_mem_sel=1; next state LOAD.
REQ-027 LOAD: exc_mem_sel=1, exc_done=1; pc <= {24'b0, mem_byte}; next state IDLE.
REQ-028 Total sequence: 4 edges from request to pc loaded; exc_busy high for 3 cycles (FETCH, WAIT, LOAD).
REQ-029 While busy: pc_write, pc_write_cond and all exception requests are ignored; epc and exc_addr hold.
REQ-030 epc changes only on entry to FETCH; exc_addr changes only on entry to FETCH.
REQ-031 pc = 0 with an exception: epc = 32'hFFFFFFFC (wrap-around, no flag).
REQ-032 exc_mem_sel, exc_busy and exc_done are decoded from state only (no input dependence).

Reset
REQ-033 reset high at any time, including mid-sequence: pc=0, epc=0, exc_addr=0, state=IDLE, exc_mem_sel=0, exc_busy=0, exc_done=0, asynchronously.
REQ-034 After reset deasserts, the first edge behaves as IDLE; no pending exception is remembered.

Verification
REQ-035 pc=0x100, pc_next=0x104, pc_write=1 -> next edge pc=0x104; pc_write=0, pc_write_cond=0 -> pc holds.
REQ-036 pc_write_cond=1 with each branch_op/flag combination, e.g. bne with alu_zero=1 -> pc holds; bgt with alu_gt=1 -> pc=pc_next.
REQ-037 pc=0x40, exc_ovf=1 and pc_write=1 at the same edge -> epc=0x3C, exc_addr=254, pc stays 0x40; mem_byte=0x80 in LOAD -> pc=0x00000080, exc_done pulse, IDLE.
REQ-038 exc_opcode=exc_ovf=exc_div0=1 together -> exc_addr=253; exc_div0 pulsed during WAIT -> ignored, epc unchanged.
REQ-039 reset asserted in WAIT -> pc=0, epc=0, outputs low immediately; a later exception runs the full 4-edge sequence.
REQ-040 pc=0, exc_div0=1 -> epc=0xFFFFFFFC, exc_addr=255.
